ccd_pixel_capture: RTL and testbench

//  ADC-side receiver for the CCD readout sequencer. Watches ad_adclk/ad_oeb_n and samples
//  the 8-bit muxed ADC bus: MSB on each ad_adclk fall, LSB on each ad_adclk rise.

---
 rtl/ccd_pixel_capture_if.sv | 26 ++
 rtl/ccd_pixel_capture.sv | 233 +++++++++++++++++++++++
 tb/tb_ccd_pixel_capture.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ccd_pixel_capture_if.sv
// ----------------------------------------------------------------------------
// ccd_pixel_capture_if
// Pixel stream from the CCD ADC capture block toward the host-transfer logic.
//
// Signals
//   pix_data   16  pixel word {MSB,LSB}
//   pix_valid   1  pix_data/pix_sol hold a pixel
//   pix_ready   1  consumer can take the pixel this cycle
//   pix_sol     1  pixel is the first kept pixel of a row
//
// Handshake: a pixel transfers on every rising clk edge where pix_valid and
// pix_ready are both high. Once pix_valid is high, pix_data and pix_sol hold
// their value and pix_valid stays high until that transfer happens. The
// producer never waits for pix_ready before raising pix_valid.
//
// Modports: master = producer (capture block), slave = consumer.
// ----------------------------------------------------------------------------
interface ccd_pixel_capture_if;
    logic [15:0] pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic        pix_sol;

    modport master (output pix_data, output pix_valid, output pix_sol, input pix_ready);
    modport slave  (input pix_data, input pix_valid, input pix_sol, output pix_ready);
endinterface

// File: rtl/ccd_pixel_capture.sv
// ----------------------------------------------------------------------------
// ccd_pixel_capture
// ADC-side receiver for the CCD readout sequencer. Detects ad_adclk/ad_oeb_n
// edges in the clk domain, samples the muxed 8-bit ADC bus DATA_DELAY cycles
// after each ad_adclk edge (MSB on fall, LSB on rise), builds 16-bit pixels,
// drops the first ROW_DISCARD pixels of each row and buffers kept pixels in a
// first-word-fall-through FIFO feeding a valid/ready stream.
//
// Ports
//   clk        in   system clock (sequencer outputs are synchronous to it)
//   rst_n      in   asynchronous active-low reset
//   arm        in   1-cycle pulse: flush FIFO, clear overflow/pix_count, capture
//   ad_adclk   in   ADC sample clock from the sequencer
//   ad_oeb_n   in   ADC output enable, active low (high between rows)
//   ad_data    in   8-bit muxed ADC data
//   pix        master modport of ccd_pixel_capture_if (pixel stream)
//   overflow   out  sticky: a kept pixel was dropped because the FIFO was full
//   pix_count  out  pixels written into the FIFO since arm (wraps)
//   fsm_state  out  current capture state, for debug/observation
//
// Configuration macro: CCD_CAPTURE_TESTPATTERN_EN
//   When defined, the sampled ADC bytes are replaced by a 16-bit counter that
//   advances once per assembled pixel (discarded ones included).
// ----------------------------------------------------------------------------
module ccd_pixel_capture #(
    parameter int DATA_DELAY  = 2,
    parameter int ROW_DISCARD = 3,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       arm,
    input  logic                       ad_adclk,
    input  logic                       ad_oeb_n,
    input  logic [7:0]                 ad_data,
    ccd_pixel_capture_if.master        pix,
    output logic                       overflow,
    output logic [23:0]                pix_count,
    output logic [1:0]                 fsm_state
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int DW = (ROW_DISCARD < 2) ? 1 : $clog2(ROW_DISCARD + 1);
    localparam logic [DW-1:0] DISCARD_INIT = DW'(ROW_DISCARD);
    localparam logic [2:0]    DLY_LOAD     = 3'((DATA_DELAY > 0) ? DATA_DELAY - 1 : 0);

    typedef enum logic [1:0] {IDLE, WAIT_ROW, WAIT_MSB, WAIT_LSB} state_t;
    state_t state, state_nx;

    // ---------------- edge detection ----------------
    logic adclk_q, oeb_q;
    logic edge_rise, edge_fall, oeb_fall, oeb_rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            adclk_q <= 1'b1;
            oeb_q   <= 1'b1;
        end else begin
            adclk_q <= ad_adclk;
            oeb_q   <= ad_oeb_n;
        end
    end

    // ad_adclk edges only count while the registered enable is low
    assign edge_rise = ~oeb_q & ad_adclk & ~adclk_q;
    assign edge_fall = ~oeb_q & ~ad_adclk & adclk_q;
    assign oeb_fall  = oeb_q & ~ad_oeb_n;
    assign oeb_rise  = ~oeb_q & ad_oeb_n;

    // ---------------- sample delay ----------------
    // A new edge always reloads the counter, so a sample still pending from
    // the previous edge is abandoned.
    logic       dly_pend, dly_kind_rise;
    logic [2:0] dly_cnt;
    logic       smp_fire, smp_rise;

    always_comb begin
        smp_fire = 1'b0;
        smp_rise = 1'b0;
        if (DATA_DELAY == 0) begin
            smp_fire = edge_rise | edge_fall;
            smp_rise = edge_rise;
        end else if (dly_pend && !(edge_rise || edge_fall) && dly_cnt == 3'd0) begin
            smp_fire = 1'b1;
            smp_rise = dly_kind_rise;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dly_pend      <= 1'b0;
            dly_kind_rise <= 1'b0;
            dly_cnt       <= 3'd0;
        end else if (edge_rise || edge_fall) begin
            dly_pend      <= (DATA_DELAY != 0);
            dly_kind_rise <= edge_rise;
            dly_cnt       <= DLY_LOAD;
        end else if (dly_pend) begin
            if (dly_cnt == 3'd0) dly_pend <= 1'b0;
            else                 dly_cnt  <= dly_cnt - 3'd1;
        end
    end

    // ---------------- sampled bytes ----------------
    logic [7:0] smp_msb, smp_lsb;
    logic       emit;

`ifdef CCD_CAPTURE_TESTPATTERN_EN
    logic [15:0] tp_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    tp_cnt <= 16'd0;
        else if (arm)  tp_cnt <= 16'd0;
        else if (emit) tp_cnt <= tp_cnt + 16'd1;
    end

    assign smp_msb = tp_cnt[15:8];
    assign smp_lsb = tp_cnt[7:0];
`else
    assign smp_msb = ad_data;
    assign smp_lsb = ad_data;
`endif

    // ---------------- FSM ----------------
    logic load_msb, row_start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        load_msb  = 1'b0;
        emit      = 1'b0;
        row_start = 1'b0;
        if (arm) begin
            state_nx = WAIT_ROW;
        end else begin
            case (state)
                IDLE: ;
                WAIT_ROW: begin
                    if (oeb_fall) begin
                        state_nx  = WAIT_MSB;
                        row_start = 1'b1;
                    end
                end
                WAIT_MSB: begin
                    if (oeb_rise) begin
                        state_nx = WAIT_ROW;
                    end else if (smp_fire && !smp_rise) begin
                        load_msb = 1'b1;
                        state_nx = WAIT_LSB;
                    end
                end
                WAIT_LSB: begin
                    if (oeb_rise) begin
                        state_nx = WAIT_ROW;
                    end else if (smp_fire) begin
                        if (smp_rise) begin
                            emit     = 1'b1;
                            state_nx = WAIT_MSB;
                        end else begin
                            load_msb = 1'b1;
                        end
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    assign fsm_state = state;

    // ---------------- discard, FIFO, counters ----------------
    logic [7:0]    msb_reg;
    logic [DW-1:0] discard_cnt;
    logic          sol_pend;
    logic [AW:0]   wr_ptr, rd_ptr;
    logic [16:0]   mem [FIFO_DEPTH];
    logic [16:0]   mem_rd;
    logic          keep, push, pop, full, empty;

    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign keep   = emit && (discard_cnt == '0);
    assign pop    = ~empty & pix.pix_ready;
    // a pop in the same cycle frees the slot, so a full FIFO still accepts
    assign push   = keep & (~full | pop);
    assign mem_rd = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            msb_reg     <= 8'd0;
            discard_cnt <= '0;
            sol_pend    <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            overflow    <= 1'b0;
            pix_count   <= 24'd0;
        end else begin
            if (load_msb) msb_reg <= smp_msb;
            if (arm) begin
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                overflow  <= 1'b0;
                pix_count <= 24'd0;
            end else begin
                if (row_start) begin
                    discard_cnt <= DISCARD_INIT;
                    sol_pend    <= 1'b1;
                end
                if (emit && discard_cnt != '0) discard_cnt <= discard_cnt - 1'b1;
                if (push) begin
                    wr_ptr    <= wr_ptr + 1'b1;
                    sol_pend  <= 1'b0;
                    pix_count <= pix_count + 24'd1;
                end else if (keep) begin
                    overflow <= 1'b1;
                end
                if (pop) rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= {sol_pend, msb_reg, smp_lsb};
    end

    // first-word-fall-through: head entry drives the stream directly
    assign pix.pix_valid = ~empty;
    assign pix.pix_data  = empty ? 16'h0000 : mem_rd[15:0];
    assign pix.pix_sol   = ~empty & mem_rd[16];
endmodule

// File: tb/tb_ccd_pixel_capture.sv
// ----------------------------------------------------------------------------
// tb_ccd_pixel_capture
// Drives sequencer-like ad_adclk/ad_oeb_n/ad_data waveforms and compares the
// pixel stream, pix_count and overflow with a row-level reference model.
// ----------------------------------------------------------------------------
module tb_ccd_pixel_capture;
    localparam int DATA_DELAY  = 2;
    localparam int ROW_DISCARD = 3;
    localparam int FIFO_DEPTH  = 8;
    localparam int HALF        = 4;

    // ---------------- clock / reset ----------------
    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        arm      = 1'b0;
    logic        ad_adclk = 1'b1;
    logic        ad_oeb_n = 1'b1;
    logic [7:0]  ad_data  = 8'h00;
    logic        overflow;
    logic [23:0] pix_count;
    logic [1:0]  fsm_state;

    ccd_pixel_capture_if pix_if();

    ccd_pixel_capture #(
        .DATA_DELAY (DATA_DELAY),
        .ROW_DISCARD(ROW_DISCARD),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .arm      (arm),
        .ad_adclk (ad_adclk),
        .ad_oeb_n (ad_oeb_n),
        .ad_data  (ad_data),
        .pix      (pix_if),
        .overflow (overflow),
        .pix_count(pix_count),
        .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    // ---------------- scoreboard / model state ----------------
    int          n_checks  = 0;
    int          n_errors  = 0;
    logic [16:0] exp_q[$];
    int          ready_mode = 0;     // 0: never ready, 1: always, 2: random
    int          model_count = 0;
    bit          model_ovf   = 1'b0;
    int          row_idx     = 0;
    bit          row_sol     = 1'b0;
    logic [15:0] model_tp    = 16'd0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One assembled pixel in a live row: first ROW_DISCARD dropped, the next
    // one carries start-of-line, a stalled FIFO holds FIFO_DEPTH pixels.
    task automatic model_emit(logic [7:0] msb, logic [7:0] lsb);
        logic [15:0] w;
`ifdef CCD_CAPTURE_TESTPATTERN_EN
        w = model_tp;
        model_tp = model_tp + 16'd1;
`else
        w = {msb, lsb};
`endif
        if (row_idx < ROW_DISCARD) begin
            row_idx++;
        end else if (ready_mode == 0 && exp_q.size() >= FIFO_DEPTH) begin
            model_ovf = 1'b1;
        end else begin
            exp_q.push_back({row_sol, w});
            row_sol = 1'b0;
            model_count++;
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        model_count = 0;
        model_ovf   = 1'b0;
        model_tp    = 16'd0;
    endtask

    // ---------------- drivers ----------------
    task automatic wait_clks(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_arm();
        arm = 1'b1;
        wait_clks(1);
        arm = 1'b0;
        model_clear();
    endtask

    task automatic send_pixel(logic [7:0] msb, logic [7:0] lsb, bit live);
        ad_adclk = 1'b0;
        ad_data  = msb;
        wait_clks(HALF);
        ad_adclk = 1'b1;
        ad_data  = lsb;
        if (live) model_emit(msb, lsb);
        wait_clks(HALF);
    endtask

    task automatic row_begin();
        ad_oeb_n = 1'b0;
        row_idx  = 0;
        row_sol  = 1'b1;
        wait_clks(3);
    endtask

    task automatic row_end();
        wait_clks(3);
        ad_oeb_n = 1'b1;
        wait_clks(4);
    endtask

    // partial: finish with an MSB-only half pixel, then close the row
    task automatic send_row(int n, bit partial, bit live);
        row_begin();
        for (int i = 0; i < n; i++) send_pixel(8'($urandom), 8'($urandom), live);
        if (partial) begin
            ad_adclk = 1'b0;
            ad_data  = 8'($urandom);
            wait_clks(HALF);
            ad_oeb_n = 1'b1;
            wait_clks(2);
            ad_adclk = 1'b1;
            wait_clks(4);
        end else begin
            row_end();
        end
    endtask

    task automatic wait_drain(string tag);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || pix_if.pix_valid) && k < 500) begin
            wait_clks(1);
            k++;
        end
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    // ---------------- consumer ----------------
    initial begin
        pix_if.pix_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       pix_if.pix_ready = 1'b0;
                1:       pix_if.pix_ready = 1'b1;
                default: pix_if.pix_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    initial begin
        logic [16:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && pix_if.pix_valid && pix_if.pix_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pix", {15'd0, pix_if.pix_sol, pix_if.pix_data}, 32'hffff_ffff);
                end else begin
                    e = exp_q.pop_front();
                    check("pix_data", 32'(pix_if.pix_data), 32'(e[15:0]));
                    check("pix_sol", 32'(pix_if.pix_sol), 32'(e[16]));
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- test sequence ----------------
    logic [7:0] t1_msb [5];
    logic [7:0] t1_lsb [5];

    initial begin
        t1_msb = '{8'h12, 8'h56, 8'h9a, 8'hde, 8'hf0};
        t1_lsb = '{8'h34, 8'h78, 8'hbc, 8'h01, 8'h0f};

        wait_clks(3);
        check("rst_valid", 32'(pix_if.pix_valid), 32'd0);
        check("rst_data",  32'(pix_if.pix_data),  32'd0);
        check("rst_sol",   32'(pix_if.pix_sol),   32'd0);
        check("rst_ovf",   32'(overflow),         32'd0);
        check("rst_count", 32'(pix_count),        32'd0);
        rst_n = 1'b1;
        wait_clks(2);

        // bus activity before the first arm is ignored
        ready_mode = 1;
        send_row(5, 1'b0, 1'b0);
        check("idle_count", 32'(pix_count), 32'd0);
        check("idle_valid", 32'(pix_if.pix_valid), 32'd0);

        // 1: single row of five pixels, last two kept
        do_arm();
        row_begin();
        for (int i = 0; i < 5; i++) send_pixel(t1_msb[i], t1_lsb[i], 1'b1);
        row_end();
        wait_drain("t1_drain");
        check("t1_count", 32'(pix_count), 32'd2);
        check("t1_ovf",   32'(overflow),  32'd0);

        // 2: two rows, discard and start-of-line restart per row
        ready_mode = 2;
        send_row(6, 1'b0, 1'b1);
        send_row(4, 1'b0, 1'b1);
        wait_drain("t2_drain");
        check("t2_count", 32'(pix_count), 32'(model_count));
        check("t2_count_abs", 32'(pix_count), 32'd6);

        // 3: stalled consumer, ten kept pixels into an eight-deep FIFO
        ready_mode = 0;
        wait_clks(2);
        do_arm();
        send_row(13, 1'b0, 1'b1);
        check("t3_valid", 32'(pix_if.pix_valid), 32'd1);
        check("t3_ovf",   32'(overflow),         32'd1);
        check("t3_count", 32'(pix_count),        32'd8);
        check("t3_model_ovf", 32'(overflow), 32'(model_ovf));
        ready_mode = 1;
        wait_drain("t3_drain");
        check("t3_ovf_sticky", 32'(overflow), 32'd1);
        do_arm();
        check("t3_ovf_clear", 32'(overflow), 32'd0);

        // 4: MSB-only row end leaves nothing behind
        send_row(0, 1'b1, 1'b1);
        check("t4_count_partial", 32'(pix_count), 32'd0);
        check("t4_valid_partial", 32'(pix_if.pix_valid), 32'd0);
        send_row(5, 1'b0, 1'b1);
        wait_drain("t4_drain");
        check("t4_count", 32'(pix_count), 32'd2);

        // 5a: arm in the middle of a row
        ready_mode = 0;
        wait_clks(2);
        do_arm();
        row_begin();
        for (int i = 0; i < 5; i++) send_pixel(8'($urandom), 8'($urandom), 1'b1);
        check("t5a_valid_before", 32'(pix_if.pix_valid), 32'd1);
        check("t5a_count_before", 32'(pix_count), 32'd2);
        do_arm();
        check("t5a_valid_after", 32'(pix_if.pix_valid), 32'd0);
        check("t5a_count_after", 32'(pix_count), 32'd0);
        for (int i = 0; i < 2; i++) send_pixel(8'($urandom), 8'($urandom), 1'b0);
        row_end();
        check("t5a_valid_rowend", 32'(pix_if.pix_valid), 32'd0);
        ready_mode = 1;
        send_row(5, 1'b0, 1'b1);
        wait_drain("t5a_drain");
        check("t5a_count", 32'(pix_count), 32'd2);

        // 5b: reset in the middle of a row
        ready_mode = 0;
        wait_clks(2);
        row_begin();
        for (int i = 0; i < 4; i++) send_pixel(8'($urandom), 8'($urandom), 1'b1);
        ad_adclk = 1'b0;
        wait_clks(1);
        #2;
        rst_n = 1'b0;
        #1;
        model_clear();
        check("t5b_valid", 32'(pix_if.pix_valid), 32'd0);
        check("t5b_data",  32'(pix_if.pix_data),  32'd0);
        check("t5b_sol",   32'(pix_if.pix_sol),   32'd0);
        check("t5b_count", 32'(pix_count),        32'd0);
        check("t5b_ovf",   32'(overflow),         32'd0);
        wait_clks(2);
        rst_n    = 1'b1;
        ad_oeb_n = 1'b1;
        ad_adclk = 1'b1;
        wait_clks(4);
        ready_mode = 1;
        do_arm();
        send_row(6, 1'b0, 1'b1);
        wait_drain("t5b_drain");
        check("t5b_count_after", 32'(pix_count), 32'd3);

        // randomized rows, lengths and half-pixel row ends
        ready_mode = 2;
        for (int r = 0; r < 8; r++) begin
            send_row($urandom_range(0, 9), 1'($urandom_range(0, 1)), 1'b1);
        end
        wait_drain("rnd_drain");
        check("rnd_count", 32'(pix_count), 32'(model_count));
        check("rnd_ovf",   32'(overflow),  32'(model_ovf));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
